// File: rtl/alu_ex_stage.sv
// Execute-stage ALU with a registered result, a branch compare flag and an
// iterative shifter (SHIFT_STEP bits per cycle) behind valid/ready handshakes.
module alu_ex_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] pc,
  input  logic [4:0]      rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            cmp_true,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam int unsigned SHW = 6;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_LT   = 4'd8;
  localparam logic [3:0] ALU_LTU  = 4'd9;
  localparam logic [3:0] ALU_GE   = 4'd10;
  localparam logic [3:0] ALU_GEU  = 4'd11;
  localparam logic [3:0] ALU_EQ   = 4'd12;
  localparam logic [3:0] ALU_NE   = 4'd13;
  localparam logic [3:0] ALU_PC4  = 4'd14;

  localparam logic [1:0] SK_SLL = 2'd0;
  localparam logic [1:0] SK_SRL = 2'd1;
  localparam logic [1:0] SK_SRA = 2'd2;

  localparam logic [SHW-1:0] STEP = SHW'(SHIFT_STEP);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [SHW-1:0]    rem_q, rem_d;
  logic [1:0]        kind_q, kind_d;
  logic [4:0]        pend_rd_q, pend_rd_d;
  logic [XLEN-1:0]   result_d;
  logic              cmp_d, out_valid_d, busy_d;

  logic              accept;
  logic              in_is_shift;
  logic [1:0]        in_kind;
  logic [XLEN-1:0]   alu_res;
  logic              alu_cmp;
  logic [SHW-1:0]    sh_rem, sh_amt, rem_nxt;
  logic [XLEN-1:0]   sh_src, sh_out;
  logic [1:0]        sh_kind;

  function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] x,
                                               input logic [SHW-1:0]  amt,
                                               input logic [1:0]      kind);
    case (kind)
      SK_SLL:  shift_by = x << amt;
      SK_SRL:  shift_by = x >> amt;
      default: shift_by = XLEN'($signed(x) >>> amt);
    endcase
  endfunction

  assign in_ready = rst_n & ~flush & ~busy & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Decode of the shift class of the incoming op
  always_comb begin
    in_is_shift = 1'b0;
    in_kind     = SK_SLL;
    case (alu_control)
      ALU_SLL: begin in_is_shift = 1'b1; in_kind = SK_SLL; end
      ALU_SRL: begin in_is_shift = 1'b1; in_kind = SK_SRL; end
      ALU_SRA: begin in_is_shift = 1'b1; in_kind = SK_SRA; end
      default: ;
    endcase
  end

  // Single-cycle ALU for everything except shifts
  always_comb begin
    alu_res = '0;
    alu_cmp = 1'b0;
    case (alu_control)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_LT:  begin alu_res = XLEN'($signed(op_a) <  $signed(op_b)); alu_cmp = alu_res[0]; end
      ALU_LTU: begin alu_res = XLEN'(op_a <  op_b);                   alu_cmp = alu_res[0]; end
      ALU_GE:  begin alu_res = XLEN'($signed(op_a) >= $signed(op_b)); alu_cmp = alu_res[0]; end
      ALU_GEU: begin alu_res = XLEN'(op_a >= op_b);                   alu_cmp = alu_res[0]; end
      ALU_EQ:  begin alu_res = XLEN'(op_a == op_b);                   alu_cmp = alu_res[0]; end
      ALU_NE:  begin alu_res = XLEN'(op_a != op_b);                   alu_cmp = alu_res[0]; end
      ALU_PC4: alu_res = pc + XLEN'(4);
      default: ;
    endcase
  end

  // Shared shifter: first step from the operand in IDLE, later steps from acc
  assign sh_rem  = (state_q == SHIFT) ? rem_q  : (in_is_shift ? SHW'(op_b[4:0]) : '0);
  assign sh_src  = (state_q == SHIFT) ? acc_q  : op_a;
  assign sh_kind = (state_q == SHIFT) ? kind_q : in_kind;
  assign sh_amt  = (sh_rem > STEP) ? STEP : sh_rem;
  assign sh_out  = shift_by(sh_src, sh_amt, sh_kind);
  assign rem_nxt = sh_rem - sh_amt;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && in_is_shift && (rem_nxt != '0)) state_d = SHIFT;
      SHIFT:   if (rem_nxt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    acc_d       = acc_q;
    rem_d       = rem_q;
    kind_d      = kind_q;
    pend_rd_d   = pend_rd_q;
    result_d    = result;
    cmp_d       = cmp_true;
    out_valid_d = out_valid;
    busy_d      = busy;
    out_rd_d_blk: begin end
    if (state_q == IDLE) begin
      if (accept) begin
        if (!in_is_shift || (rem_nxt == '0)) begin
          result_d    = in_is_shift ? sh_out : alu_res;
          cmp_d       = in_is_shift ? 1'b0 : alu_cmp;
          pend_rd_d   = rd;
          out_valid_d = 1'b1;
        end else begin
          acc_d       = sh_out;
          rem_d       = rem_nxt;
          kind_d      = in_kind;
          pend_rd_d   = rd;
          busy_d      = 1'b1;
          out_valid_d = 1'b0;
        end
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end else begin
      acc_d = sh_out;
      rem_d = rem_nxt;
      if (rem_nxt == '0) begin
        result_d    = sh_out;
        cmp_d       = 1'b0;
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
      end
    end
    if (flush) begin
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end
  end

  // out_rd follows the tag of whichever op just produced a result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      rem_q     <= '0;
      kind_q    <= SK_SLL;
      pend_rd_q <= '0;
      result    <= '0;
      cmp_true  <= 1'b0;
      out_rd    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      kind_q    <= kind_d;
      pend_rd_q <= pend_rd_d;
      result    <= result_d;
      cmp_true  <= cmp_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      if (out_valid_d && !out_valid_q_hold(out_valid, out_ready, flush)) out_rd <= pend_rd_d;
    end
  end

  function automatic logic out_valid_q_hold(input logic ov, input logic ordy, input logic fl);
    out_valid_q_hold = ov & ~ordy & ~fl;
  endfunction

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: directed corner cases plus a randomized
// run scored against a transaction-level reference model.
module tb_alu_ex_stage;

  localparam int unsigned STEP = 1;

  localparam logic [3:0] C_ADD = 4'd0,  C_SUB = 4'd1,  C_XOR = 4'd2,  C_OR  = 4'd3;
  localparam logic [3:0] C_AND = 4'd4,  C_SLL = 4'd5,  C_SRL = 4'd6,  C_SRA = 4'd7;
  localparam logic [3:0] C_LT  = 4'd8,  C_LTU = 4'd9,  C_GE  = 4'd10, C_GEU = 4'd11;
  localparam logic [3:0] C_EQ  = 4'd12, C_NE  = 4'd13, C_PC4 = 4'd14;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic        cmp_true, busy;
  logic [3:0]  alu_control;
  logic [31:0] op_a, op_b, pc, result;
  logic [4:0]  rd, out_rd;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  alu_ex_stage #(.XLEN(32), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .op_a(op_a), .op_b(op_b), .pc(pc), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cmp_true(cmp_true),
    .out_rd(out_rd), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic straight from the operation table
  function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] p);
    int sh;
    sh = int'(b[4:0]);
    case (c)
      C_ADD: return a + b;
      C_SUB: return a - b;
      C_XOR: return a ^ b;
      C_OR:  return a | b;
      C_AND: return a & b;
      C_SLL: return a << sh;
      C_SRL: return a >> sh;
      C_SRA: return (a >> sh) | ((a[31] && sh > 0) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      C_LT:  return ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
      C_LTU: return (a <  b) ? 32'd1 : 32'd0;
      C_GE:  return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      C_GEU: return (a >= b) ? 32'd1 : 32'd0;
      C_EQ:  return (a == b) ? 32'd1 : 32'd0;
      C_NE:  return (a != b) ? 32'd1 : 32'd0;
      C_PC4: return p + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_cmp(input logic [3:0] c);
    return (c >= C_LT) && (c <= C_NE);
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if ((c == C_SLL || c == C_SRL || c == C_SRA) && sh > 0) return (sh + STEP - 1) / STEP;
    return 1;
  endfunction

  typedef struct {
    logic [31:0] res;
    logic        cmp;
    logic [4:0]  rd;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  bit   head_timed = 1'b0;

  // Scoreboard: in-order expected outputs, value and latency checked
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || flush) begin
      q.delete();
      head_timed = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("sb_spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          if (!head_timed) begin
            check("sb_latency", 64'(cyc - q[0].acc_cyc), 64'(q[0].lat));
            head_timed = 1'b1;
          end
          if (out_ready) begin
            e = q.pop_front();
            head_timed = 1'b0;
            check("sb_result", 64'(result), 64'(e.res));
            check("sb_cmp", 64'(cmp_true), 64'(e.cmp));
            check("sb_rd", 64'(out_rd), 64'(e.rd));
          end
        end
      end
      if (in_valid && in_ready) begin
        e.res     = ref_res(alu_control, op_a, op_b, pc);
        e.cmp     = is_cmp(alu_control) ? e.res[0] : 1'b0;
        e.rd      = rd;
        e.lat     = ref_lat(alu_control, op_b);
        e.acc_cyc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r);
    in_valid = 1'b1; alu_control = c; op_a = a; op_b = b; rd = r;
  endtask

  int stray;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = C_ADD; op_a = '0; op_b = '0; pc = 32'h0000_1000; rd = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;

    // Wrap-around add
    set_op(C_ADD, 32'hFFFF_FFFF, 32'd1, 5'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_result", 64'(result), 64'd0);
    check("add_cmp", 64'(cmp_true), 64'd0);
    tick();

    // Back-to-back ops, one result per cycle
    set_op(C_SUB, 32'd5, 32'd7, 5'd2);
    tick();
    set_op(C_LT, 32'hFFFF_FFFF, 32'd1, 5'd3);
    @(negedge clk);
    check("b2b_sub", 64'(result), 64'hFFFF_FFFE);
    tick();
    set_op(C_GEU, 32'd1, 32'hFFFF_FFFF, 5'd4);
    @(negedge clk);
    check("b2b_lt", 64'(result), 64'd1);
    check("b2b_lt_cmp", 64'(cmp_true), 64'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_geu", 64'(result), 64'd0);
    check("b2b_geu_cmp", 64'(cmp_true), 64'd0);
    check("b2b_geu_valid", 64'(out_valid), 64'd1);
    tick();

    // Iterative arithmetic shift
    set_op(C_SRA, 32'h8000_0000, 32'd5, 5'd5);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sra_busy", 64'(busy), 64'd1);
      check("sra_in_ready", 64'(in_ready), 64'd0);
      check("sra_not_valid", 64'(out_valid), 64'd0);
      tick();
    end
    @(negedge clk);
    check("sra_valid", 64'(out_valid), 64'd1);
    check("sra_result", 64'(result), 64'hFC00_0000);
    check("sra_busy_done", 64'(busy), 64'd0);
    tick();
    set_op(C_SRA, 32'h8000_0000, 32'h0000_0020, 5'd6);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("sra0_valid", 64'(out_valid), 64'd1);
    check("sra0_result", 64'(result), 64'h8000_0000);
    tick();

    // Output backpressure
    out_ready = 1'b0;
    set_op(C_ADD, 32'd3, 32'd4, 5'd7);
    tick();
    set_op(C_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_result", 64'(result), 64'd7);
      check("stall_rd", 64'(out_rd), 64'd7);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("unstall_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("unstall_valid", 64'(out_valid), 64'd1);
    check("unstall_result", 64'(result), 64'hFF00_FF00);
    check("unstall_rd", 64'(out_rd), 64'd8);
    tick();

    // Flush mid-shift with a competing input in the flush cycle
    set_op(C_SLL, 32'd1, 32'd20, 5'd9);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    flush = 1'b1;
    set_op(C_ADD, 32'd1, 32'd2, 5'd10);
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("flush_no_output", 64'(stray), 64'd0);
    set_op(C_ADD, 32'd10, 32'd20, 5'd11);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("post_flush_result", 64'(result), 64'd30);
    check("post_flush_valid", 64'(out_valid), 64'd1);
    tick();

    // Reset mid-shift, then reset with a pending output
    set_op(C_SRL, 32'hFFFF_FFFF, 32'd10, 5'd12);
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", 64'(in_ready), 64'd0);
    tick();
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_result", 64'(result), 64'd0);
    check("rst_mid_rd", 64'(out_rd), 64'd0);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b0;
    set_op(C_EQ, 32'd9, 32'd9, 5'd13);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_ov_pre", 64'(cmp_true), 64'd1);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("rst_ov_valid", 64'(out_valid), 64'd0);
    check("rst_ov_result", 64'(result), 64'd0);
    check("rst_ov_cmp", 64'(cmp_true), 64'd0);
    check("rst_ov_rd", 64'(out_rd), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 1500; i++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      alu_control = 4'($urandom_range(0, 15));
      op_a        = $urandom();
      op_b        = ($urandom_range(0, 3) == 0) ? op_a : $urandom();
      pc          = $urandom();
      rd          = 5'($urandom());
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 49) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    @(negedge clk);
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
